// File: rtl/io_master.sv
// io_master: single-outstanding command engine for a small I/O register space.
// Accepts read / write / bit-set / bit-clear commands, drives the I/O memory
// port, and returns one response per command.
// Optional feature macro: IO_MASTER_RMW_EN enables the bit-set / bit-clear
// read-modify-write ops; without it those ops are rejected as errors.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// READ  | sampling io_data_in at the latched address
// WRITE | one-cycle io_write_enable strobe with io_data_out
// RESP  | response held until rsp_ready
module io_master #(
    parameter logic [7:0] IO_MAX = 8'h08
) (
    input  logic       clock,
    input  logic       reset_s2,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_address,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic [7:0] io_address,
    output logic [7:0] io_data_out,
    output logic       io_write_enable,
    input  logic [7:0] io_data_in,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_out_q, data_out_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_error_q, rsp_error_d;
    logic       op_enabled;
    logic       cmd_ok;
`ifdef IO_MASTER_RMW_EN
    logic [1:0] op_q, op_d;
`endif

    // Command legality: address in range (0xFF never writable) and op supported
    always_comb begin
`ifdef IO_MASTER_RMW_EN
        op_enabled = 1'b1;
`else
        op_enabled = (cmd_op == 2'b00) || (cmd_op == 2'b01);
`endif
        cmd_ok = (cmd_address <= IO_MAX) && (cmd_address != 8'hFF) && op_enabled;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_out_d  = data_out_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifdef IO_MASTER_RMW_EN
        op_d        = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_address;
`ifdef IO_MASTER_RMW_EN
                    op_d   = cmd_op;
`endif
                    if (!cmd_ok) begin
                        rsp_error_d = 1'b1;
                        rsp_data_d  = 8'h00;
                        state_d     = RESP;
                    end else begin
                        rsp_error_d = 1'b0;
                        if (cmd_op == 2'b01) begin
                            data_out_d = cmd_data;
                            state_d    = WRITE;
                        end else begin
`ifdef IO_MASTER_RMW_EN
                            // the mask waits in data_out_q until the READ cycle
                            if (cmd_op[1]) begin
                                data_out_d = cmd_data;
                            end
`endif
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                rsp_data_d = io_data_in;
                state_d    = RESP;
`ifdef IO_MASTER_RMW_EN
                if (op_q[1]) begin
                    data_out_d = op_q[0] ? (io_data_in & ~data_out_q)
                                         : (io_data_in | data_out_q);
                    state_d    = WRITE;
                end
`endif
            end
            WRITE: begin
                rsp_data_d = data_out_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, async reset discards any command in flight
    always_ff @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            state_q     <= IDLE;
            addr_q      <= 8'h00;
            data_out_q  <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
`ifdef IO_MASTER_RMW_EN
            op_q        <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_out_q  <= data_out_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
`ifdef IO_MASTER_RMW_EN
            op_q        <= op_d;
`endif
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        cmd_ready       = (state_q == IDLE) && !reset_s2;
        rsp_valid       = (state_q == RESP);
        busy            = (state_q != IDLE);
        io_write_enable = (state_q == WRITE);
        io_address      = addr_q;
        io_data_out     = data_out_q;
        rsp_data        = rsp_data_q;
        rsp_error       = rsp_error_q;
    end

endmodule

// File: tb/tb_io_master.sv
// Directed-vector bench for io_master with a small I/O memory model.
module tb_io_master;

    logic       clock = 1'b0;
    logic       reset_s2 = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_address = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic [7:0] io_address;
    logic [7:0] io_data_out;
    logic       io_write_enable;
    logic [7:0] io_data_in;
    logic       busy;

    int checks = 0;
    int errors = 0;

    io_master #(.IO_MAX(8'h08)) dut (
        .clock(clock),
        .reset_s2(reset_s2),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_address(cmd_address),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_error(rsp_error),
        .io_address(io_address),
        .io_data_out(io_data_out),
        .io_write_enable(io_write_enable),
        .io_data_in(io_data_in),
        .busy(busy)
    );

    always #10 clock = ~clock;

    // I/O memory model: preloaded during reset, counts and applies write strobes
    logic [7:0] mem [0:255];
    int         wr_cnt = 0;
    logic [7:0] wr_last = 8'h00;

    assign io_data_in = mem[io_address];

    always @(negedge clock) begin
        if (io_write_enable) begin
            wr_cnt           <= wr_cnt + 1;
            wr_last          <= io_data_out;
            mem[io_address]  <= io_data_out;
        end
        if (reset_s2) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[2] <= 8'hA5;
            mem[5] <= 8'h0F;
            mem[6] <= 8'h0F;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Issue one command from a negedge; return cycles from accept edge to rsp_valid
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                           output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        cmd_op      = op;
        cmd_address = addr;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) begin
            lat = 99;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_wr;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat;
        int w0;

        vecs[0] = '{2'b01, 8'h00, 8'hFF, 8'hFF, 1'b0, 2, 1, 8'hFF};
        vecs[1] = '{2'b00, 8'h02, 8'h00, 8'hA5, 1'b0, 2, 0, 8'h00};
        vecs[2] = '{2'b00, 8'h00, 8'h00, 8'hFF, 1'b0, 2, 0, 8'h00};
        vecs[3] = '{2'b01, 8'h08, 8'h3C, 8'h3C, 1'b0, 2, 1, 8'h3C};
        vecs[4] = '{2'b00, 8'h08, 8'h00, 8'h3C, 1'b0, 2, 0, 8'h00};
        vecs[5] = '{2'b01, 8'h09, 8'h77, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[6] = '{2'b01, 8'hFF, 8'h11, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[7] = '{2'b00, 8'h09, 8'h00, 8'h00, 1'b1, 1, 0, 8'h00};
`ifdef IO_MASTER_RMW_EN
        vecs[8]  = '{2'b10, 8'h05, 8'h30, 8'h3F, 1'b0, 3, 1, 8'h3F};
        vecs[9]  = '{2'b11, 8'h06, 8'h03, 8'h0C, 1'b0, 3, 1, 8'h0C};
        vecs[10] = '{2'b00, 8'h05, 8'h00, 8'h3F, 1'b0, 2, 0, 8'h00};
`else
        vecs[8]  = '{2'b10, 8'h05, 8'h30, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[9]  = '{2'b11, 8'h06, 8'h03, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[10] = '{2'b00, 8'h05, 8'h00, 8'h0F, 1'b0, 2, 0, 8'h00};
`endif

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_io_address", io_address, 8'h00);
        chk("rst_io_data_out", io_data_out, 8'h00);
        chk("rst_io_we", io_write_enable, 0);
        reset_s2 = 1'b0;
        @(negedge clock);
        chk("rel_cmd_ready", cmd_ready, 1);

        // table-driven commands, rsp_ready held high
        for (int v = 0; v < 11; v++) begin
            w0 = wr_cnt;
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].data, lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].exp_data);
            chk($sformatf("v%0d_rsp_error", v), rsp_error, vecs[v].exp_err);
            chk($sformatf("v%0d_io_address", v), io_address, vecs[v].addr);
            @(negedge clock);
            chk($sformatf("v%0d_resp_one_cycle", v), rsp_valid, 0);
            chk($sformatf("v%0d_write_count", v), wr_cnt - w0, vecs[v].exp_wr);
            if (vecs[v].exp_wr > 0) begin
                chk($sformatf("v%0d_write_data", v), wr_last, vecs[v].exp_wdata);
            end
        end

        // response held while rsp_ready is low
        rsp_ready = 1'b0;
        run_cmd(2'b01, 8'h03, 8'h5A, lat);
        chk("hold_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, 8'h5A);
            chk("hold_rsp_error", rsp_error, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("release_rsp_valid", rsp_valid, 0);
        chk("release_cmd_ready", cmd_ready, 1);

        // reset mid-command, during the READ cycle
`ifdef IO_MASTER_RMW_EN
        cmd_op = 2'b10;
`else
        cmd_op = 2'b00;
`endif
        cmd_address = 8'h06;
        cmd_data    = 8'hF0;
        cmd_valid   = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("mid_busy", busy, 1);
        chk("mid_io_we", io_write_enable, 0);
        w0 = wr_cnt;
        reset_s2 = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 8'h00);
        chk("mid_rst_rsp_error", rsp_error, 0);
        chk("mid_rst_io_address", io_address, 8'h00);
        chk("mid_rst_io_data_out", io_data_out, 8'h00);
        chk("mid_rst_io_we", io_write_enable, 0);
        repeat (2) @(negedge clock);
        chk("mid_rst_no_write", wr_cnt - w0, 0);
        reset_s2 = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_no_write", wr_cnt - w0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_master.md
IO_MASTER -- requirements
Module: io_master

Interface
REQ-001 The block SHALL have parameter IO_MAX, default 8'h08, meaning the highest valid I/O address; the lowest valid address is 8'h00.
REQ-002 The block SHALL have port clock, input, 1 bit: 50 MHz system clock, all state on its rising edge.
REQ-003 The block SHALL have port reset_s2, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 2 bits: 00 read, 01 write, 10 bit-set, 11 bit-clear.
REQ-007 The block SHALL have port cmd_address, input, 8 bits: target I/O address.
REQ-008 The block SHALL have port cmd_data, input, 8 bits: write data, or the mask for set/clear.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 The block SHALL have port rsp_data, output, 8 bits: response data.
REQ-012 The block SHALL have port rsp_error, output, 1 bit: the command was rejected.
REQ-013 The block SHALL have port io_address, output, 8 bits: address to the I/O memory.
REQ-014 The block SHALL have port io_data_out, output, 8 bits: write data to the I/O memory.
REQ-015 The block SHALL have port io_write_enable, output, 1 bit: write strobe to the I/O memory.
REQ-016 The block SHALL have port io_data_in, input, 8 bits: combinational read data from the I/O memory at io_address.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, READ, WRITE, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid && cmd_ready, and op, address and data SHALL be latched at that edge.
REQ-020 Only one command SHALL be outstanding; no new command SHALL be accepted until the response has been consumed.
REQ-021 io_address SHALL be driven from the latched address from the accept edge onward, and SHALL hold its value in IDLE.
REQ-022 If the address is > IO_MAX, or the op is not enabled, the next state SHALL be RESP with rsp_error=1 and rsp_data=8'h00, with no io_write_enable pulse.
REQ-023 A read SHALL go IDLE -> READ; in READ, io_data_in SHALL be captured into rsp_data, then the next state SHALL be RESP, giving rsp_valid 2 cycles after the accept edge.
REQ-024 A write SHALL go IDLE -> WRITE; in WRITE, io_write_enable SHALL be 1 for exactly one cycle with io_data_out equal to cmd_data, and rsp_data SHALL equal cmd_data; then the next state SHALL be RESP.
REQ-025 Set and clear SHALL go IDLE -> READ -> WRITE -> RESP; in READ the register value SHALL be captured; in WRITE io_data_out SHALL be (value | mask) for set or (value & ~mask) for clear; rsp_data SHALL be the written value; rsp_valid SHALL be high 3 cycles after the accept edge.
REQ-026 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_error SHALL be stable until rsp_ready=1; on that edge the next state SHALL be IDLE, with rsp_valid low the next cycle.
REQ-027 If rsp_ready is already 1 on RESP entry, RESP SHALL last exactly one cycle.
REQ-028 io_write_enable SHALL be 0 in every state other than WRITE.
REQ-029 Address 8'hFF, and any address above IO_MAX, SHALL never cause io_write_enable.

Reset
REQ-030 When reset_s2=1, the block SHALL immediately return to IDLE, including mid-command, with no further write strobe.
REQ-031 Reset SHALL set cmd_ready=0 while reset_s2=1, and 1 after release.
REQ-032 Reset SHALL set rsp_valid=0, rsp_data=8'h00, rsp_error=0, io_address=8'h00, io_data_out=8'h00, io_write_enable=0 and busy=0.
REQ-033 A response pending when reset asserts SHALL be discarded.

Configuration
REQ-034 With macro IO_MASTER_RMW_EN defined, the set and clear ops SHALL behave as in REQ-025.
REQ-035 Without IO_MASTER_RMW_EN, ops 10 and 11 SHALL be rejected per REQ-022, with no READ or WRITE cycles and no RMW logic synthesised.

Verification
REQ-036 A bench SHALL cover: write op=01, addr 8'h00, data 8'hFF -> one io_write_enable pulse, io_data_out=8'hFF; rsp_data=8'hFF, rsp_error=0.
REQ-037 A bench SHALL cover: read addr 8'h02 with io_data_in=8'hA5 -> rsp_valid 2 cycles after accept, rsp_data=8'hA5.
REQ-038 A bench SHALL cover: with RMW enabled and the register reading 8'h0F, set with mask 8'h30 -> write 8'h3F; clear with mask 8'h03 -> write 8'h0C.
REQ-039 A bench SHALL cover: write addr 8'h09 -> rsp_error=1, rsp_data=8'h00, no write pulse; and without the macro, op=10 -> rsp_error=1.
REQ-040 A bench SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_error stable, cmd_ready=0 throughout.
REQ-041 A bench SHALL cover: reset_s2 pulsed during the READ of a set op -> no io_write_enable, state IDLE, all outputs at their REQ-032 values.
